adxl345_irq_sequencer: RTL and testbench
========================================

Name: adxl345_irq_sequencer

Overview:
Controller that drives the team's I2C master command interface to bring up an ADXL345 and then service its interrupt line. After reset it checks DEVID, writes four configuration registers and waits for IRQ. On each IRQ it reads INT_SOURCE. When DATA_READY is set, it burst-reads DATAX0..DATAZ1 and presents one X/Y/Z sample. It sits between the I2C master and the sample consumer; the device-imitation bench model is its test target.

Parameters:
DEVICE_ADDR, 7'h53, 7-bit I2C slave address
BW_RATE_VAL, 8'h0A, value written to 0x2C
POWER_CTL_VAL, 8'h08, value written to 0x2D (measure)
INT_ENABLE_VAL, 8'h80, value written to 0x2E (DATA_READY)
DATA_FORMAT_VAL, 8'h08, value written to 0x31
TIMEOUT, 1000000, max cycles from CMD accept to DONE/NACK

Ports:
CLK  in  1  clock
RESETN  in  1  reset, asynchronous, active-low
ENABLE  in  1  level; low holds sequencer in IDLE/clears ERROR
IRQ  in  1  ADXL345 INT1, asynchronous, active-high
CMD_ADDR  out  7  slave address
CMD_RW  out  1  1=read, 0=write
CMD_PTR  out  8  register pointer
CMD_LEN  out  8  payload byte count (excluding pointer)
CMD_VALID  out  1  command request
CMD_READY  in  1  master accepts command
WDATA  out  8  write payload byte
WVALID  out  1  payload valid
WREADY  in  1  master consumed byte
RDATA  in  8  read byte
RVALID  in  1  one-cycle strobe per read byte
DONE  in  1  one-cycle transaction complete (ACKed)
NACK  in  1  one-cycle transaction aborted
SAMPLE_X, SAMPLE_Y, SAMPLE_Z  out  16  signed, little-endian assembled
SAMPLE_VALID  out  1  one-cycle strobe
INT_SOURCE  out  8  last INT_SOURCE byte read
READY  out  1  init complete, in IDLE
ERROR  out  1  DEVID mismatch, NACK or timeout

Behaviour:
- Reset: all outputs 0. CMD_ADDR = DEVICE_ADDR constant. State = ID_CMD.
- IRQ passes through a 2-FF synchroniser. The IDLE trigger is the level of the synchronised IRQ, not its edge. A pending IRQ that is never read therefore re-triggers.
- Command handshake: CMD_ADDR/RW/PTR/LEN and CMD_VALID are stable until the cycle where CMD_VALID & CMD_READY; CMD_VALID drops the next cycle.
- Write payload: WDATA/WVALID are presented after command acceptance and held until WREADY.
- Read bytes: captured on RVALID in order; a byte counter indexes them.
- Timeout counter: cleared on command accept; while waiting for DONE/NACK it increments; reaching TIMEOUT goes to ERROR.
- NACK in any wait state goes to ERROR. DONE/NACK outside a wait state is ignored.
- ID_CMD: read, PTR 0x00, LEN 1.
- ID_WAIT: on DONE, captured byte == 8'hE5 goes to CFG_CMD(idx 0); otherwise ERROR.
- CFG_CMD/CFG_DATA/CFG_WAIT: write, LEN 1, sequence idx 0..3 = (0x2C,BW_RATE_VAL), (0x31,DATA_FORMAT_VAL), (0x2E,INT_ENABLE_VAL), (0x2D,POWER_CTL_VAL).
  - On DONE with idx<3, increment idx.
  - On DONE with idx 3, go to IDLE and set READY=1.
- IDLE: on ENABLE & irq_sync, go to ISRC_CMD.
- ISRC_CMD/ISRC_WAIT: read, PTR 0x30, LEN 1. On DONE, INT_SOURCE <= byte.
  - If byte[7]=1, go to XYZ_CMD; else IDLE.
- XYZ_CMD/XYZ_WAIT: read, PTR 0x32, LEN 6. Bytes b0..b5 give X={b1,b0}, Y={b3,b2}, Z={b5,b4}.
  - On DONE with exactly 6 bytes received, SAMPLE_* are updated and SAMPLE_VALID=1 for one cycle. The sample registers hold until the next update. State returns to IDLE.
  - DONE with ≠6 bytes goes to ERROR.
  - RVALID beyond 6 bytes is ignored.
- ERROR: ERROR=1, READY=0, no commands issued. Leaves only when ENABLE=0, restarting at ID_CMD with ERROR cleared.
- ENABLE=0 mid-transaction: the current transaction completes, then the block stays in IDLE. ENABLE only gates new IRQ service and ERROR recovery.
- RESETN asserted mid-transaction: immediate return to reset values. CMD_VALID/WVALID drop asynchronously.
- DONE and RVALID in the same cycle: the byte is captured first, then DONE is evaluated with the updated count.

Test Plan:
- Reset, slave model returns DEVID 0xE5 and ACKs everything -> four writes (0x2C=0x0A, 0x31=0x08, 0x2E=0x80, 0x2D=0x08) in order, then READY=1, ERROR=0.
- Model returns DEVID 0x00 -> ERROR=1, no CFG command issued; pulse ENABLE low -> restart with ID read of 0x00.
- IRQ high, INT_SOURCE=0x80, data bytes 0A 00 F3 FF 09 00 -> exactly one SAMPLE_VALID pulse with X=0x000A, Y=0xFFF3, Z=0x0009, INT_SOURCE=0x80.
- IRQ high, INT_SOURCE=0x02 -> no XYZ read, no SAMPLE_VALID, return to IDLE.
- NACK during the CFG idx 2 write -> ERROR=1; DONE never asserted with TIMEOUT=100 -> ERROR after 100 cycles.
- RESETN pulled low during XYZ_WAIT after 3 bytes -> all outputs 0 immediately; after release, full init sequence repeats.

Source files
------------

// File: rtl/adxl345_irq_sequencer.sv
// ADXL345 bring-up and interrupt service sequencer driving an I2C master command port.
// Verifies DEVID, writes four config registers, then reads INT_SOURCE / XYZ on each IRQ.
module adxl345_irq_sequencer #(
    parameter logic [6:0] DEVICE_ADDR     = 7'h53,
    parameter logic [7:0] BW_RATE_VAL     = 8'h0A,
    parameter logic [7:0] POWER_CTL_VAL   = 8'h08,
    parameter logic [7:0] INT_ENABLE_VAL  = 8'h80,
    parameter logic [7:0] DATA_FORMAT_VAL = 8'h08,
    parameter int         TIMEOUT         = 1000000
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        enable_i,
    input  logic        irq_i,
    output logic [6:0]  cmd_addr_o,
    output logic        cmd_rw_o,
    output logic [7:0]  cmd_ptr_o,
    output logic [7:0]  cmd_len_o,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    output logic [7:0]  wdata_o,
    output logic        wvalid_o,
    input  logic        wready_i,
    input  logic [7:0]  rdata_i,
    input  logic        rvalid_i,
    input  logic        done_i,
    input  logic        nack_i,
    output logic [15:0] sample_x_o,
    output logic [15:0] sample_y_o,
    output logic [15:0] sample_z_o,
    output logic        sample_valid_o,
    output logic [7:0]  int_source_o,
    output logic        ready_o,
    output logic        error_o
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [3:0] {
        S_ID_CMD, S_ID_WAIT, S_CFG_CMD, S_CFG_DATA, S_CFG_WAIT, S_IDLE,
        S_ISRC_CMD, S_ISRC_WAIT, S_XYZ_CMD, S_XYZ_WAIT, S_ERROR
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    bytes_q [6];
    logic [7:0]    bytes_d [6];
    logic          irq_meta_q, irq_sync_q;
    logic          cmd_rw_q, cmd_rw_d, cmd_valid_q, cmd_valid_d, wvalid_q, wvalid_d;
    logic [7:0]    cmd_ptr_q, cmd_ptr_d, cmd_len_q, cmd_len_d, wdata_q, wdata_d;
    logic [7:0]    int_source_q, int_source_d;
    logic [15:0]   sx_q, sx_d, sy_q, sy_d, sz_q, sz_d;
    logic          sample_valid_q, sample_valid_d, ready_q, ready_d, error_q, error_d;
    logic          cmd_accept, in_wait, rd_wait, timed_out;

    // Configuration write order: rate and format first, interrupt enable, then measure mode last.
    function automatic logic [7:0] cfg_ptr(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h2C;
            2'd1:    return 8'h31;
            2'd2:    return 8'h2E;
            default: return 8'h2D;
        endcase
    endfunction

    function automatic logic [7:0] cfg_val(input logic [1:0] idx);
        case (idx)
            2'd0:    return BW_RATE_VAL;
            2'd1:    return DATA_FORMAT_VAL;
            2'd2:    return INT_ENABLE_VAL;
            default: return POWER_CTL_VAL;
        endcase
    endfunction

    assign cmd_accept = cmd_valid_q & cmd_ready_i;
    assign in_wait    = state_q inside {S_ID_WAIT, S_CFG_DATA, S_CFG_WAIT, S_ISRC_WAIT, S_XYZ_WAIT};
    assign rd_wait    = state_q inside {S_ID_WAIT, S_ISRC_WAIT, S_XYZ_WAIT};
    assign timed_out  = in_wait && (tmo_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        tmo_d          = tmo_q;
        bytes_d        = bytes_q;
        int_source_d   = int_source_q;
        sx_d           = sx_q;
        sy_d           = sy_q;
        sz_d           = sz_q;
        sample_valid_d = 1'b0;
        cmd_rw_d       = cmd_rw_q;
        cmd_ptr_d      = cmd_ptr_q;
        cmd_len_d      = cmd_len_q;
        wdata_d        = wdata_q;

        // Byte capture precedes DONE evaluation so a same-cycle DONE sees the updated count.
        if (rd_wait && rvalid_i && cnt_q < 3'd6) begin
            for (int i = 0; i < 6; i++) begin
                if (cnt_q == 3'(i)) bytes_d[i] = rdata_i;
            end
            cnt_d = cnt_q + 3'd1;
        end
        if (in_wait) tmo_d = tmo_q + TW'(1);

        unique case (state_q)
            S_ID_CMD, S_CFG_CMD, S_ISRC_CMD, S_XYZ_CMD: begin
                if (cmd_accept) begin
                    cnt_d = 3'd0;
                    tmo_d = '0;
                    case (state_q)
                        S_ID_CMD:   state_d = S_ID_WAIT;
                        S_CFG_CMD:  state_d = S_CFG_DATA;
                        S_ISRC_CMD: state_d = S_ISRC_WAIT;
                        default:    state_d = S_XYZ_WAIT;
                    endcase
                end
            end
            S_ID_WAIT: begin
                if (nack_i) state_d = S_ERROR;
                else if (done_i) begin
                    if (cnt_d != 3'd0 && bytes_d[0] == 8'hE5) begin
                        state_d = S_CFG_CMD;
                        idx_d   = 2'd0;
                    end else begin
                        state_d = S_ERROR;
                    end
                end else if (timed_out) state_d = S_ERROR;
            end
            S_CFG_DATA: begin
                if (nack_i) state_d = S_ERROR;
                else if (wvalid_q && wready_i) state_d = S_CFG_WAIT;
                else if (timed_out) state_d = S_ERROR;
            end
            S_CFG_WAIT: begin
                if (nack_i) state_d = S_ERROR;
                else if (done_i) begin
                    if (idx_q == 2'd3) state_d = S_IDLE;
                    else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_CFG_CMD;
                    end
                end else if (timed_out) state_d = S_ERROR;
            end
            S_IDLE: begin
                if (enable_i && irq_sync_q) state_d = S_ISRC_CMD;
            end
            S_ISRC_WAIT: begin
                if (nack_i) state_d = S_ERROR;
                else if (done_i) begin
                    if (cnt_d == 3'd0) state_d = S_ERROR;
                    else begin
                        int_source_d = bytes_d[0];
                        state_d      = bytes_d[0][7] ? S_XYZ_CMD : S_IDLE;
                    end
                end else if (timed_out) state_d = S_ERROR;
            end
            S_XYZ_WAIT: begin
                if (nack_i) state_d = S_ERROR;
                else if (done_i) begin
                    if (cnt_d == 3'd6) begin
                        sx_d           = {bytes_d[1], bytes_d[0]};
                        sy_d           = {bytes_d[3], bytes_d[2]};
                        sz_d           = {bytes_d[5], bytes_d[4]};
                        sample_valid_d = 1'b1;
                        state_d        = S_IDLE;
                    end else begin
                        state_d = S_ERROR;
                    end
                end else if (timed_out) state_d = S_ERROR;
            end
            S_ERROR: begin
                if (!enable_i) begin
                    state_d = S_ID_CMD;
                    idx_d   = 2'd0;
                end
            end
            default: state_d = S_ERROR;
        endcase

        // Command fields are registered from the next state so they are stable while CMD_VALID is high.
        case (state_d)
            S_ID_CMD:   begin cmd_rw_d = 1'b1; cmd_ptr_d = 8'h00;          cmd_len_d = 8'd1; end
            S_CFG_CMD:  begin cmd_rw_d = 1'b0; cmd_ptr_d = cfg_ptr(idx_d); cmd_len_d = 8'd1; end
            S_ISRC_CMD: begin cmd_rw_d = 1'b1; cmd_ptr_d = 8'h30;          cmd_len_d = 8'd1; end
            S_XYZ_CMD:  begin cmd_rw_d = 1'b1; cmd_ptr_d = 8'h32;          cmd_len_d = 8'd6; end
            S_CFG_DATA: wdata_d = cfg_val(idx_d);
            default: ;
        endcase
        cmd_valid_d = state_d inside {S_ID_CMD, S_CFG_CMD, S_ISRC_CMD, S_XYZ_CMD};
        wvalid_d    = (state_d == S_CFG_DATA);
        ready_d     = (state_d == S_IDLE);
        error_d     = (state_d == S_ERROR);
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q        <= S_ID_CMD;
            idx_q          <= '0;
            cnt_q          <= '0;
            tmo_q          <= '0;
            for (int i = 0; i < 6; i++) bytes_q[i] <= '0;
            irq_meta_q     <= 1'b0;
            irq_sync_q     <= 1'b0;
            cmd_rw_q       <= 1'b0;
            cmd_ptr_q      <= '0;
            cmd_len_q      <= '0;
            cmd_valid_q    <= 1'b0;
            wdata_q        <= '0;
            wvalid_q       <= 1'b0;
            int_source_q   <= '0;
            sx_q           <= '0;
            sy_q           <= '0;
            sz_q           <= '0;
            sample_valid_q <= 1'b0;
            ready_q        <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            tmo_q          <= tmo_d;
            bytes_q        <= bytes_d;
            irq_meta_q     <= irq_i;
            irq_sync_q     <= irq_meta_q;
            cmd_rw_q       <= cmd_rw_d;
            cmd_ptr_q      <= cmd_ptr_d;
            cmd_len_q      <= cmd_len_d;
            cmd_valid_q    <= cmd_valid_d;
            wdata_q        <= wdata_d;
            wvalid_q       <= wvalid_d;
            int_source_q   <= int_source_d;
            sx_q           <= sx_d;
            sy_q           <= sy_d;
            sz_q           <= sz_d;
            sample_valid_q <= sample_valid_d;
            ready_q        <= ready_d;
            error_q        <= error_d;
        end
    end

    assign cmd_addr_o     = DEVICE_ADDR;
    assign cmd_rw_o       = cmd_rw_q;
    assign cmd_ptr_o      = cmd_ptr_q;
    assign cmd_len_o      = cmd_len_q;
    assign cmd_valid_o    = cmd_valid_q;
    assign wdata_o        = wdata_q;
    assign wvalid_o       = wvalid_q;
    assign sample_x_o     = sx_q;
    assign sample_y_o     = sy_q;
    assign sample_z_o     = sz_q;
    assign sample_valid_o = sample_valid_q;
    assign int_source_o   = int_source_q;
    assign ready_o        = ready_q;
    assign error_o        = error_q;

endmodule

// File: tb/tb_adxl345_irq_sequencer.sv
// Directed bench for adxl345_irq_sequencer: an I2C-master stand-in answers commands from
// record tables; multi-cycle corner cases (timeout, reset mid-read) are hand-sequenced.
module tb_adxl345_irq_sequencer;

    localparam int RESP_DONE = 0;
    localparam int RESP_NACK = 1;
    localparam int RESP_NONE = 2;

    logic        clk = 1'b0, resetn = 1'b0, enable = 1'b1, irq = 1'b0;
    logic        cmd_ready = 1'b0, wready = 1'b0, rvalid = 1'b0, done = 1'b0, nack = 1'b0;
    logic [7:0]  rdata = 8'h00;
    logic [6:0]  cmd_addr_o;
    logic        cmd_rw_o, cmd_valid_o, wvalid_o, sample_valid_o, ready_o, error_o;
    logic [7:0]  cmd_ptr_o, cmd_len_o, wdata_o, int_source_o;
    logic [15:0] sample_x_o, sample_y_o, sample_z_o;

    int n_cmp = 0, n_bad = 0, sv_cnt = 0;

    typedef struct {
        logic        rw;
        logic [7:0]  ptr;
        logic [7:0]  len;
        logic [7:0]  wdata;
        logic [55:0] rb;      // read bytes, byte i at [8*i +: 8]
        int          nrb;
        bit          ovl;     // DONE/NACK in the same cycle as the last RVALID
        int          resp;
    } cmd_rec_t;

    typedef struct {
        cmd_rec_t    rec;
        logic [15:0] x, y, z;
    } smp_rec_t;

    cmd_rec_t init_tbl [5];
    smp_rec_t smp_tbl  [3];

    adxl345_irq_sequencer #(.TIMEOUT(100)) dut (
        .clk_i(clk), .resetn_i(resetn), .enable_i(enable), .irq_i(irq),
        .cmd_addr_o(cmd_addr_o), .cmd_rw_o(cmd_rw_o), .cmd_ptr_o(cmd_ptr_o),
        .cmd_len_o(cmd_len_o), .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready),
        .wdata_o(wdata_o), .wvalid_o(wvalid_o), .wready_i(wready),
        .rdata_i(rdata), .rvalid_i(rvalid), .done_i(done), .nack_i(nack),
        .sample_x_o(sample_x_o), .sample_y_o(sample_y_o), .sample_z_o(sample_z_o),
        .sample_valid_o(sample_valid_o), .int_source_o(int_source_o),
        .ready_o(ready_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (sample_valid_o) sv_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic cmd_rec_t mk(input logic rw, input logic [7:0] ptr, input logic [7:0] len,
                                    input logic [7:0] wd, input logic [55:0] rb, input int nrb,
                                    input bit ovl, input int resp);
        cmd_rec_t r;
        r.rw = rw; r.ptr = ptr; r.len = len; r.wdata = wd;
        r.rb = rb; r.nrb = nrb; r.ovl = ovl; r.resp = resp;
        return r;
    endfunction

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Plays the I2C master side of one transaction described by r.
    task automatic run_cmd(input cmd_rec_t r, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (cmd_valid_o) seen = 1'b1;
        end
        check_eq({name, " cmd_valid"}, 64'(seen), 64'(1));
        if (!seen) return;
        check_eq({name, " cmd"}, 64'({cmd_addr_o, cmd_rw_o, cmd_ptr_o, cmd_len_o}),
                 64'({7'h53, r.rw, r.ptr, r.len}));
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        irq = 1'b0;
        check_eq({name, " valid_drop"}, 64'(cmd_valid_o), 64'(0));
        if (!r.rw) begin
            for (int i = 0; i < 20 && !wvalid_o; i++) @(negedge clk);
            check_eq({name, " wdata"}, 64'({wvalid_o, wdata_o}), 64'({1'b1, r.wdata}));
            wready = 1'b1;
            @(negedge clk);
            wready = 1'b0;
        end
        for (int b = 0; b < r.nrb; b++) begin
            rdata  = r.rb[8*b +: 8];
            rvalid = 1'b1;
            if (r.ovl && b == r.nrb - 1) begin
                done = (r.resp == RESP_DONE);
                nack = (r.resp == RESP_NACK);
            end
            @(negedge clk);
            rvalid = 1'b0;
            done   = 1'b0;
            nack   = 1'b0;
        end
        if (!(r.ovl && r.nrb > 0) && r.resp != RESP_NONE) begin
            done = (r.resp == RESP_DONE);
            nack = (r.resp == RESP_NACK);
            @(negedge clk);
            done = 1'b0;
            nack = 1'b0;
        end
    endtask

    task automatic run_init(input string tag);
        for (int i = 0; i < 5; i++) run_cmd(init_tbl[i], $sformatf("%s init[%0d]", tag, i));
        check_eq({tag, " ready/error"}, 64'({ready_o, error_o}), 64'(2'b10));
    endtask

    task automatic check_no_cmd(input int cycles, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (cmd_valid_o) seen = 1'b1;
        end
        check_eq(name, 64'(seen), 64'(0));
    endtask

    task automatic pulse_enable_low();
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
    endtask

    function automatic logic [37:0] ctrl_bits();
        return {cmd_valid_o, cmd_rw_o, cmd_ptr_o, cmd_len_o, wdata_o, wvalid_o,
                sample_valid_o, int_source_o, ready_o, error_o};
    endfunction

    initial begin
        cmd_rec_t r;
        cmd_rec_t isrc80;

        init_tbl[0] = mk(1'b1, 8'h00, 8'd1, 8'h00, 56'hE5, 1, 1'b0, RESP_DONE);
        init_tbl[1] = mk(1'b0, 8'h2C, 8'd1, 8'h0A, 56'h0, 0, 1'b0, RESP_DONE);
        init_tbl[2] = mk(1'b0, 8'h31, 8'd1, 8'h08, 56'h0, 0, 1'b0, RESP_DONE);
        init_tbl[3] = mk(1'b0, 8'h2E, 8'd1, 8'h80, 56'h0, 0, 1'b0, RESP_DONE);
        init_tbl[4] = mk(1'b0, 8'h2D, 8'd1, 8'h08, 56'h0, 0, 1'b0, RESP_DONE);
        isrc80      = mk(1'b1, 8'h30, 8'd1, 8'h00, 56'h80, 1, 1'b0, RESP_DONE);
        smp_tbl[0].rec = mk(1'b1, 8'h32, 8'd6, 8'h00, 56'h00_00_09_FF_F3_00_0A, 6, 1'b0, RESP_DONE);
        smp_tbl[0].x = 16'h000A; smp_tbl[0].y = 16'hFFF3; smp_tbl[0].z = 16'h0009;
        smp_tbl[1].rec = mk(1'b1, 8'h32, 8'd6, 8'h00, 56'hFF_80_00_AB_CD_12_34, 7, 1'b0, RESP_DONE);
        smp_tbl[1].x = 16'h1234; smp_tbl[1].y = 16'hABCD; smp_tbl[1].z = 16'h8000;
        smp_tbl[2].rec = mk(1'b1, 8'h32, 8'd6, 8'h00, 56'h00_AA_55_7F_FE_80_01, 6, 1'b1, RESP_DONE);
        smp_tbl[2].x = 16'h8001; smp_tbl[2].y = 16'h7FFE; smp_tbl[2].z = 16'hAA55;

        // Reset values
        @(negedge clk);
        check_eq("reset ctrl", 64'(ctrl_bits()), 64'(0));
        check_eq("reset samples", 64'({sample_x_o, sample_y_o, sample_z_o}), 64'(0));
        check_eq("reset cmd_addr", 64'(cmd_addr_o), 64'(7'h53));
        resetn = 1'b1;

        run_init("boot");

        // IRQ-driven sample reads (7th byte ignored; DONE on last RVALID)
        for (int s = 0; s < 3; s++) begin
            irq = 1'b1;
            run_cmd(isrc80, $sformatf("smp%0d isrc", s));
            run_cmd(smp_tbl[s].rec, $sformatf("smp%0d xyz", s));
            check_eq($sformatf("smp%0d valid", s), 64'(sample_valid_o), 64'(1));
            check_eq($sformatf("smp%0d xyz_val", s), 64'({sample_x_o, sample_y_o, sample_z_o}),
                     64'({smp_tbl[s].x, smp_tbl[s].y, smp_tbl[s].z}));
            check_eq($sformatf("smp%0d int_source", s), 64'(int_source_o), 64'(8'h80));
            @(negedge clk);
            check_eq($sformatf("smp%0d valid_pulse_end", s), 64'(sample_valid_o), 64'(0));
        end

        // ENABLE low blocks IRQ service; INT_SOURCE without DATA_READY returns to IDLE
        enable = 1'b0;
        irq    = 1'b1;
        check_no_cmd(20, "enable_low no service");
        enable = 1'b1;
        r = isrc80; r.rb = 56'h02;
        run_cmd(r, "isrc02");
        check_eq("isrc02 int_source", 64'(int_source_o), 64'(8'h02));
        check_no_cmd(20, "isrc02 no xyz");
        check_eq("isrc02 ready", 64'({ready_o, error_o}), 64'(2'b10));
        check_eq("sample pulse count", 64'(sv_cnt), 64'(3));

        // Short XYZ burst -> ERROR, samples untouched
        irq = 1'b1;
        run_cmd(isrc80, "short isrc");
        r = smp_tbl[0].rec; r.nrb = 5;
        run_cmd(r, "short xyz");
        check_eq("short error", 64'({ready_o, error_o}), 64'(2'b01));
        check_eq("short samples held", 64'(sample_x_o), 64'(16'h8001));

        // Bad DEVID -> ERROR, no CFG command
        pulse_enable_low();
        r = init_tbl[0]; r.rb = 56'h00;
        run_cmd(r, "bad devid");
        check_eq("bad devid error", 64'({ready_o, error_o}), 64'(2'b01));
        check_no_cmd(20, "bad devid no cfg");

        // NACK on CFG idx 2
        pulse_enable_low();
        for (int i = 0; i < 3; i++) run_cmd(init_tbl[i], $sformatf("nack init[%0d]", i));
        r = init_tbl[3]; r.resp = RESP_NACK;
        run_cmd(r, "nack cfg2");
        check_eq("nack error", 64'({ready_o, error_o}), 64'(2'b01));

        // DONE never arrives: ERROR exactly TIMEOUT cycles after accept
        pulse_enable_low();
        r = init_tbl[0]; r.nrb = 0; r.resp = RESP_NONE;
        run_cmd(r, "timeout id");
        repeat (99) @(negedge clk);
        check_eq("timeout before", 64'(error_o), 64'(0));
        @(negedge clk);
        check_eq("timeout at", 64'(error_o), 64'(1));

        // Reset during XYZ_WAIT after three bytes
        pulse_enable_low();
        run_init("recover");
        irq = 1'b1;
        run_cmd(isrc80, "rst isrc");
        r = smp_tbl[0].rec; r.nrb = 3; r.resp = RESP_NONE;
        run_cmd(r, "rst xyz");
        #2 resetn = 1'b0;
        #1;
        check_eq("midreset ctrl", 64'(ctrl_bits()), 64'(0));
        check_eq("midreset samples", 64'({sample_x_o, sample_y_o, sample_z_o}), 64'(0));
        @(negedge clk);
        resetn = 1'b1;
        run_init("reboot");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
